// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W shadow scoreboard driving D-stage stall and D/E operand forwarding
module hazard_scoreboard #(
    parameter int NSRC     = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [5*NSRC-1:0]    d_src_addr,
    input  logic [2*NSRC-1:0]    d_src_tuse,
    input  logic [32*NSRC-1:0]   d_src_data,
    input  logic [4:0]           d_dst_addr,
    input  logic                 d_dst_wen,
    input  logic [1:0]           d_tnew,
    input  logic                 d_md_start,
    input  logic                 d_md_is_div,
    input  logic                 d_md_use,
    input  logic                 d_epc_wr,
    input  logic                 d_eret,
    input  logic [32*NSRC-1:0]   e_src_data,
    input  logic [31:0]          e_wd,
    input  logic [31:0]          m_wd,
    input  logic [31:0]          w_wd,
    output logic                 stall,
    output logic [32*NSRC-1:0]   d_src_fwd,
    output logic [32*NSRC-1:0]   e_src_fwd,
    output logic                 md_busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic              valid;
        logic [4:0]        dst;
        logic              wen;
        logic [1:0]        tnew;
        logic [5*NSRC-1:0] src_addr;
        logic              md_start;
        logic              md_is_div;
        logic              epc_wr;
    } slot_t;

    slot_t            e_slot, m_slot, w_slot, d_rec;
    logic [MD_W-1:0]  md_cnt;
    logic             src_stall, md_stall, eret_stall;

    function automatic logic slot_match(input slot_t s, input logic [4:0] a);
        return s.valid && s.wen && (s.dst == a) && (a != 5'd0);
    endfunction

    function automatic slot_t age(input slot_t s);
        slot_t r;
        r = s;
        if (r.tnew != 2'd0)
            r.tnew = r.tnew - 2'd1;
        return r;
    endfunction

    always_comb begin
        d_rec           = '0;
        d_rec.valid     = 1'b1;
        d_rec.dst       = d_dst_addr;
        d_rec.wen       = d_dst_wen;
        d_rec.tnew      = d_tnew;
        d_rec.src_addr  = d_src_addr;
        d_rec.md_start  = d_md_start;
        d_rec.md_is_div = d_md_is_div;
        d_rec.epc_wr    = d_epc_wr;
    end

    always_comb begin
        src_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (slot_match(e_slot, d_src_addr[5*i +: 5]) && (d_src_tuse[2*i +: 2] < e_slot.tnew))
                src_stall = 1'b1;
            if (slot_match(m_slot, d_src_addr[5*i +: 5]) && (d_src_tuse[2*i +: 2] < m_slot.tnew))
                src_stall = 1'b1;
        end
        md_stall   = d_md_use && ((e_slot.valid && e_slot.md_start) || (md_cnt != '0));
        eret_stall = d_eret && ((e_slot.valid && e_slot.epc_wr) || (m_slot.valid && m_slot.epc_wr));
        stall      = src_stall || md_stall || eret_stall;
    end

    // Only a slot whose value is already produced (tnew == 0) may supply an operand.
    always_comb begin
        d_src_fwd = d_src_data;
        e_src_fwd = e_src_data;
        for (int i = 0; i < NSRC; i++) begin
            if (slot_match(e_slot, d_src_addr[5*i +: 5]) && (e_slot.tnew == 2'd0))
                d_src_fwd[32*i +: 32] = e_wd;
            else if (slot_match(m_slot, d_src_addr[5*i +: 5]) && (m_slot.tnew == 2'd0))
                d_src_fwd[32*i +: 32] = m_wd;
            else if (slot_match(w_slot, d_src_addr[5*i +: 5]) && (w_slot.tnew == 2'd0))
                d_src_fwd[32*i +: 32] = w_wd;

            if (slot_match(m_slot, e_slot.src_addr[5*i +: 5]) && (m_slot.tnew == 2'd0))
                e_src_fwd[32*i +: 32] = m_wd;
            else if (slot_match(w_slot, e_slot.src_addr[5*i +: 5]) && (w_slot.tnew == 2'd0))
                e_src_fwd[32*i +: 32] = w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot    <= '0;
            m_slot    <= '0;
            w_slot    <= '0;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                e_slot <= '0;
                m_slot <= '0;
                w_slot <= '0;
            end else begin
                w_slot <= age(m_slot);
                m_slot <= age(e_slot);
                e_slot <= stall ? slot_t'('0) : d_rec;
            end

            // A running count survives flush; only a new start is suppressed.
            if (e_slot.valid && e_slot.md_start && !flush)
                md_cnt <= e_slot.md_is_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - MD_W'(1);

            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

    logic unused_slot_bits;
    assign unused_slot_bits = ^{w_slot, m_slot};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam logic [63:0] D_RAW = 64'hDDDD_0001_DDDD_0000;
    localparam logic [63:0] E_RAW = 64'hEEEE_0001_EEEE_0000;
    localparam logic [31:0] EWD   = 32'hE5E5_E5E5;
    localparam logic [31:0] MWD   = 32'd7;
    localparam logic [31:0] WWD   = 32'h5757_5757;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [9:0]  d_src_addr;
    logic [3:0]  d_src_tuse;
    logic [63:0] d_src_data;
    logic [4:0]  d_dst_addr;
    logic        d_dst_wen;
    logic [1:0]  d_tnew;
    logic        d_md_start, d_md_is_div, d_md_use, d_epc_wr, d_eret;
    logic [63:0] e_src_data;
    logic [31:0] e_wd, m_wd, w_wd;
    logic        stall;
    logic [63:0] d_src_fwd, e_src_fwd;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n, nb;

    hazard_scoreboard #(.NSRC(2), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_src_addr(d_src_addr), .d_src_tuse(d_src_tuse), .d_src_data(d_src_data),
        .d_dst_addr(d_dst_addr), .d_dst_wen(d_dst_wen), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
        .d_epc_wr(d_epc_wr), .d_eret(d_eret), .e_src_data(e_src_data),
        .e_wd(e_wd), .m_wd(m_wd), .w_wd(w_wd),
        .stall(stall), .d_src_fwd(d_src_fwd), .e_src_fwd(e_src_fwd),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] s0, input logic [1:0] t0, input logic [4:0] s1,
                         input logic [1:0] t1, input logic [4:0] dst, input logic wen,
                         input logic [1:0] tn);
        d_src_addr  = {s1, s0};
        d_src_tuse  = {t1, t0};
        d_dst_addr  = dst;
        d_dst_wen   = wen;
        d_tnew      = tn;
        d_md_start  = 1'b0;
        d_md_is_div = 1'b0;
        d_md_use    = 1'b0;
        d_epc_wr    = 1'b0;
        d_eret      = 1'b0;
    endtask

    task automatic drain();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        d_src_data = D_RAW; e_src_data = E_RAW;
        e_wd = EWD; m_wd = MWD; w_wd = WWD;
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 1'b0, 2'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_md_busy", {63'd0, md_busy}, 64'd0);
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        check("rst_d_fwd", d_src_fwd, D_RAW);
        check("rst_e_fwd", e_src_fwd, E_RAW);

        // lw $1 then addu $2,$1,$3
        set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2);
        #1; check("lw_issue_stall", {63'd0, stall}, 64'd0);
        tick();
        set_d(5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 1'b1, 2'd1);
        #1; check("lw_use_stall", {63'd0, stall}, 64'd1);
        tick();
        check("lw_use_release", {63'd0, stall}, 64'd0);
        check("lw_use_d_fwd_raw", d_src_fwd, D_RAW);
        check("lw_use_stall_cnt", {32'd0, stall_cnt}, 64'd1);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1; check("lw_use_e_fwd_w", e_src_fwd, {E_RAW[63:32], WWD});
        drain();

        // ori $5,$0,7 then beq $5,$5
        set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1);
        tick();
        set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 1'b0, 2'd0);
        #1; check("beq_stall", {63'd0, stall}, 64'd1);
        tick();
        check("beq_release", {63'd0, stall}, 64'd0);
        check("beq_d_fwd_m", d_src_fwd, {MWD, MWD});
        check("beq_stall_cnt", {32'd0, stall_cnt}, 64'd2);
        drain();

        // ori $5,$0,7 then addu $6,$5,$0
        set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1);
        tick();
        set_d(5'd5, 2'd1, 5'd0, 2'd1, 5'd6, 1'b1, 2'd1);
        #1; check("addu_no_stall", {63'd0, stall}, 64'd0);
        check("addu_d_fwd_raw", d_src_fwd, D_RAW);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1; check("addu_e_fwd_m", e_src_fwd, {E_RAW[63:32], MWD});
        drain();

        // writes to $0 never stall or forward
        set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2);
        tick();
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd7, 1'b1, 2'd1);
        #1; check("r0_no_stall", {63'd0, stall}, 64'd0);
        check("r0_d_fwd_raw", d_src_fwd, D_RAW);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1; check("r0_e_fwd_raw", e_src_fwd, E_RAW);
        drain();

        // mult then mflo
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        d_md_start = 1'b1; d_md_use = 1'b1;
        #1; check("mult_issue_stall", {63'd0, stall}, 64'd0);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1);
        d_md_use = 1'b1;
        #1;
        n = 0; nb = 0;
        while (stall && n < 12) begin
            n++;
            if (md_busy) nb++;
            tick();
        end
        check("mflo_stall_cycles", 64'(n), 64'd6);
        check("mflo_busy_cycles", 64'(nb), 64'd5);
        check("mflo_busy_done", {63'd0, md_busy}, 64'd0);
        check("mflo_stall_cnt", {32'd0, stall_cnt}, 64'd8);
        drain();

        // mtc0 EPC then eret
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        d_epc_wr = 1'b1;
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        d_eret = 1'b1;
        #1;
        n = 0;
        while (stall && n < 8) begin
            n++;
            tick();
        end
        check("eret_stall_cycles", 64'(n), 64'd2);
        check("eret_stall_cnt", {32'd0, stall_cnt}, 64'd10);
        drain();

        // flush with lw in E
        set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd2, 1'b1, 2'd1);
        #1; check("flush_pre_stall", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1; check("flush_post_stall", {63'd0, stall}, 64'd0);
        check("flush_d_fwd_raw", d_src_fwd, D_RAW);
        check("flush_stall_cnt", {32'd0, stall_cnt}, 64'd11);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1; check("flush_e_fwd_raw", e_src_fwd, E_RAW);
        drain();

        // divide: flush keeps a running count, reset clears it
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        d_md_start = 1'b1; d_md_is_div = 1'b1; d_md_use = 1'b1;
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        tick();
        check("div_busy", {63'd0, md_busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1; check("div_busy_after_flush", {63'd0, md_busy}, 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1; check("div_reset_busy", {63'd0, md_busy}, 64'd0);
        check("div_reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        tick();
        check("div_reset_still_idle", {63'd0, md_busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
